// File: rtl/wdt_pkg.sv
// Shared types and defaults for the watchdog reset controller.
package wdt_pkg;

    // Escalation states of the reset controller.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IRQ  = 2'd1,
        RST  = 2'd2,
        COOL = 2'd3
    } wdt_rc_state_e;

    localparam int WDT_GRACE_DEF = 1024;
    localparam int WDT_HOLD_DEF  = 16;

    // Width of a down-counter that must hold values up to max(a,b)-1.
    // The result is never allowed below 1 bit.
    function automatic int wdt_cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/wdt_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// The reset value is a parameter so that the same cell can be reused for
// other asynchronous inputs whose idle level is 1.
module wdt_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the async level, then re-register it to settle metastability.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/wdt_rst_ctrl.sv
// Watchdog timeout reset controller.
// The WTO level from the watchdog wrapper is synchronized and edge-detected.
// A rising edge first raises an interrupt for a bounded grace window. If the
// interrupt is not acknowledged in that window, the controller drives a
// stretched active-low system reset request. A sticky cause flag and a
// saturating escalation counter are kept. Both sit on the power-on reset
// only, so they survive the system reset that this block requests.
module wdt_rst_ctrl
    import wdt_pkg::*;
#(
    parameter int GRACE_CYCLES = WDT_GRACE_DEF,
    parameter int HOLD_CYCLES  = WDT_HOLD_DEF,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wto_i,
    input  logic             irq_ack,
    input  logic             cause_clr,
    output logic             irq_wdt,
    output logic             sys_rst_n,
    output logic             rst_cause,
    output logic [CNT_W-1:0] to_count,
    output logic             busy
);

    localparam int CW = wdt_cnt_w(GRACE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] GRACE_LD = CW'(GRACE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);

    wdt_rc_state_e   state;
    logic [CW-1:0]   cnt;
    logic            wto_s;
    logic            wto_d;
    logic            wto_evt;
    logic            escalate;

    wdt_sync2 #(.RST_VAL(1'b0)) u_sync_wto (
        .clk (clk),
        .rst (rst),
        .d   (wto_i),
        .q   (wto_s)
    );

    // Delayed copy of the synchronized level for rising-edge detection.
    // It resets to 0, so a WTO that is already high at reset release counts
    // as a fresh rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wto_d <= 1'b0;
        else      wto_d <= wto_s;
    end

    assign wto_evt = wto_s & ~wto_d;

    // Grace expiry without an acknowledge in the same cycle. An acknowledge
    // wins over expiry.
    assign escalate = (state == IRQ) && !irq_ack && (cnt == '0);

    assign busy = (state != IDLE);

    // Escalation FSM. irq_wdt and sys_rst_n are assigned together with the
    // transition into the state that they reflect, so both are registered
    // copies of the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            irq_wdt   <= 1'b0;
            sys_rst_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (wto_evt) begin
                        state   <= IRQ;
                        cnt     <= GRACE_LD;
                        irq_wdt <= 1'b1;
                    end
                end
                IRQ: begin
                    if (irq_ack) begin
                        state   <= COOL;
                        irq_wdt <= 1'b0;
                    end else if (cnt == '0) begin
                        state     <= RST;
                        cnt       <= HOLD_LD;
                        irq_wdt   <= 1'b0;
                        sys_rst_n <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RST: begin
                    if (cnt == '0) begin
                        state     <= COOL;
                        sys_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                COOL: begin
                    // Wait for WTO to drop so that a level that stays high
                    // cannot re-trigger.
                    if (!wto_s) state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    irq_wdt   <= 1'b0;
                    sys_rst_n <= 1'b1;
                end
            endcase
        end
    end

    // Cause flag and saturating escalation count. A set or increment in the
    // same cycle as a clear wins, and the count restarts at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_cause <= 1'b0;
            to_count  <= '0;
        end else if (escalate) begin
            rst_cause <= 1'b1;
            if (cause_clr)
                to_count <= CNT_W'(1);
            else if (to_count != '1)
                to_count <= to_count + CNT_W'(1);
        end else if (cause_clr) begin
            rst_cause <= 1'b0;
            to_count  <= '0;
        end
    end

endmodule

// File: tb/tb_wdt_rst_ctrl.sv
// Directed bench for wdt_rst_ctrl with GRACE=8, HOLD=4, CNT_W=8.
module tb_wdt_rst_ctrl;

    localparam int G = 8;
    localparam int H = 4;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         wto_i;
    logic         irq_ack;
    logic         cause_clr;
    logic         irq_wdt;
    logic         sys_rst_n;
    logic         rst_cause;
    logic [W-1:0] to_count;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;

    wdt_rst_ctrl #(
        .GRACE_CYCLES (G),
        .HOLD_CYCLES  (H),
        .CNT_W        (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wto_i     (wto_i),
        .irq_ack   (irq_ack),
        .cause_clr (cause_clr),
        .irq_wdt   (irq_wdt),
        .sys_rst_n (sys_rst_n),
        .rst_cause (rst_cause),
        .to_count  (to_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one clock, then settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 20) begin
            step();
            k++;
        end
        chk(tag, busy, 0);
    endtask

    // Raise WTO from IDLE and check the whole unacknowledged escalation.
    // The task returns in COOL with WTO still high.
    task automatic full_esc(input string tag, input int exp_cnt);
        int hi;
        wto_i = 1'b1;
        step();                                  // E0
        step();                                  // E1
        chk({tag, "_irq_pre"}, irq_wdt, 0);
        step();                                  // E2
        chk({tag, "_irq_rise"}, irq_wdt, 1);
        chk({tag, "_busy"}, busy, 1);
        hi = 1;
        for (int i = 0; i < G - 1; i++) begin
            step();
            if (irq_wdt) hi++;
        end
        chk({tag, "_irq_len"}, hi, G);
        step();                                  // E10
        chk({tag, "_irq_fall"}, irq_wdt, 0);
        chk({tag, "_rst_fall"}, sys_rst_n, 0);
        chk({tag, "_cause"}, rst_cause, 1);
        chk({tag, "_count"}, to_count, exp_cnt);
        hi = 1;
        for (int i = 0; i < H - 1; i++) begin
            step();
            if (!sys_rst_n) hi++;
        end
        chk({tag, "_rst_len"}, hi, H);
        step();                                  // E14
        chk({tag, "_rst_rise"}, sys_rst_n, 1);
        chk({tag, "_cool"}, busy, 1);
    endtask

    // Unchecked escalation used to drive the counter to saturation.
    task automatic fast_esc();
        wto_i = 1'b1;
        repeat (15) step();
        wto_i = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        int hi;
        rst       = 1'b0;
        wto_i     = 1'b0;
        irq_ack   = 1'b0;
        cause_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq", irq_wdt, 0);
        chk("rst_sysrst", sys_rst_n, 1);
        chk("rst_cause", rst_cause, 0);
        chk("rst_count", to_count, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Acknowledge in the 3rd IRQ cycle (sampled at E5).
        wto_i = 1'b1;
        step(); step(); step();                  // E0..E2
        chk("ack_irq_rise", irq_wdt, 1);
        step(); step();                          // E3, E4
        irq_ack = 1'b1;
        step();                                  // E5
        irq_ack = 1'b0;
        chk("ack_irq_fall", irq_wdt, 0);
        chk("ack_busy", busy, 1);
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (!sys_rst_n) hi++;
        end
        chk("ack_no_rst", hi, 0);
        chk("ack_count", to_count, 0);
        wto_i = 1'b0;
        wait_idle("ack_idle");

        // Ack in the last IRQ cycle (E9->E10) collides with expiry.
        wto_i = 1'b1;
        repeat (10) step();                      // E0..E9
        chk("col_irq_last", irq_wdt, 1);
        irq_ack = 1'b1;
        step();                                  // E10
        irq_ack = 1'b0;
        chk("col_irq", irq_wdt, 0);
        chk("col_sysrst", sys_rst_n, 1);
        repeat (6) step();
        chk("col_sysrst_late", sys_rst_n, 1);
        chk("col_cause", rst_cause, 0);
        chk("col_count", to_count, 0);
        wto_i = 1'b0;
        wait_idle("col_idle");

        // Basic escalation, then park in COOL with WTO held high.
        full_esc("esc1", 1);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (irq_wdt) hi++;
        end
        chk("park_no_irq", hi, 0);
        chk("park_busy", busy, 1);
        wto_i = 1'b0;
        wait_idle("esc1_idle");

        // Retrigger after WTO drops.
        full_esc("esc2", 2);
        wto_i = 1'b0;
        wait_idle("esc2_idle");

        // Clear, then 256 escalations saturate at 255.
        cause_clr = 1'b1;
        step();
        cause_clr = 1'b0;
        chk("clr0_cause", rst_cause, 0);
        chk("clr0_count", to_count, 0);
        for (int i = 0; i < 256; i++) fast_esc();
        chk("sat_count", to_count, 255);
        chk("sat_cause", rst_cause, 1);
        chk("sat_idle", busy, 0);
        cause_clr = 1'b1;
        step();
        cause_clr = 1'b0;
        chk("clr_cause", rst_cause, 0);
        chk("clr_count", to_count, 0);

        // Clear coincident with RST entry (E10).
        wto_i = 1'b1;
        repeat (10) step();                      // E0..E9
        cause_clr = 1'b1;
        step();                                  // E10
        cause_clr = 1'b0;
        chk("coin_sysrst", sys_rst_n, 0);
        chk("coin_cause", rst_cause, 1);
        chk("coin_count", to_count, 1);

        // Asynchronous reset mid-RST with WTO still high.
        #2;
        rst = 1'b0;
        #1;
        chk("arst_sysrst", sys_rst_n, 1);
        chk("arst_irq", irq_wdt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cause", rst_cause, 0);
        chk("arst_count", to_count, 0);
        @(negedge clk);
        rst = 1'b1;
        step();                                  // E0
        step();                                  // E1
        chk("arst_irq_pre", irq_wdt, 0);
        step();                                  // E2
        chk("arst_irq_rise", irq_wdt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wdt_rst_ctrl.md
# wdt_rst_ctrl

Watchdog timeout reset controller, the stage directly downstream of the watchdog AXI wrapper. It consumes the wrapper's `WTO` timeout output and synchronizes it into the system clock domain. It then escalates the timeout in two steps: first an interrupt to the CPU with a bounded grace window, then, if software does not acknowledge, a stretched active-low system reset request. It also keeps a sticky reset-cause flag and a saturating timeout counter; both survive the reset it generates.

## Interface
- `GRACE_CYCLES`, default 1024: cycles `irq_wdt` stays high before escalating to reset; legal range ≥1.
- `HOLD_CYCLES`, default 16: cycles `sys_rst_n` is held low; legal range ≥1.
- `CNT_W`, default 8: width of `to_count`.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-low. Power-on only; it is never driven from `sys_rst_n`.
- `wto_i`  in  1  watchdog timeout from the WDT wrapper `WTO`; asynchronous to `clk`.
- `irq_ack`  in  1  single-cycle CPU acknowledge (CSR write strobe).
- `cause_clr`  in  1  single-cycle clear of `rst_cause` and `to_count`.
- `irq_wdt`  out  1  watchdog interrupt to the CPU; registered.
- `sys_rst_n`  out  1  system reset request, active-low; registered.
- `rst_cause`  out  1  sticky flag: the last system reset was caused by the watchdog.
- `to_count`  out  CNT_W  number of escalated resets; saturating.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Synchronizer: 2-flop chain on `wto_i` gives `wto_s`. A registered delay gives `wto_d`. Event condition is `wto_s & ~wto_d`.
- FSM states:
  - IDLE: on event, load `cnt` with GRACE_CYCLES-1 and go to IRQ.
  - IRQ: `irq_wdt`=1.
    - `irq_ack` goes to COOL; ack takes priority over expiry in the same cycle.
    - Otherwise, if `cnt`==0, load `cnt` with HOLD_CYCLES-1, set `rst_cause`, increment `to_count`, and go to RST.
    - Otherwise decrement `cnt`.
  - RST: `sys_rst_n`=0. When `cnt`==0 go to COOL; otherwise decrement `cnt`.
  - COOL: stay until `wto_s`==0, then go to IDLE. This prevents a still-high WTO from re-triggering.
- Outputs `irq_wdt` and `sys_rst_n` are registered from the next state; they carry no combinational path from inputs.
- `cnt` width is clog2(max(GRACE_CYCLES,HOLD_CYCLES)).
- `to_count` saturates at all-ones.
- `cause_clr` and a set/increment in the same cycle: the set/increment wins, so `rst_cause`=1 and `to_count`=1.
- `irq_ack` outside IRQ is ignored. `cause_clr` is honoured in any state.
- Events arriving in IRQ, RST or COOL are dropped; there is no queueing.
- `wto_i` falling during IRQ does not cancel escalation.

## Timing
- Reset values: `irq_wdt`=0, `sys_rst_n`=1, `rst_cause`=0, `to_count`=0, `busy`=0, FSM=IDLE, synchronizer flops=0.
- Edge naming: `wto_i` is first sampled high at edge E0.
- Latency:
  - `wto_s` is high after E1.
  - The event is seen in cycle E1→E2.
  - `irq_wdt` and `busy` go high after E2: 2 cycles of latency plus the synchronizer uncertainty.
- If `wto_i` is already high when `rst` deasserts, this counts as a rising edge, and `irq_wdt` rises 2 edges after the first sampling edge.
- Without ack, `irq_wdt` is high for exactly GRACE_CYCLES cycles.
- The `sys_rst_n` low window is contiguous with the IRQ window: `irq_wdt` falls and `sys_rst_n` falls on the same edge.
- `sys_rst_n` is low for exactly HOLD_CYCLES cycles.
- `rst_cause` and `to_count` update on the same edge that `sys_rst_n` falls.
- `irq_ack` sampled at edge Ek in IRQ makes `irq_wdt` low after Ek.
- `rst` asserted mid-operation: all state returns to reset values immediately and asynchronously, and `sys_rst_n` returns to 1. The cause flag is lost in this case.

## Structure
- `wdt_pkg`:
  - state enum `wdt_rc_state_e` {IDLE, IRQ, RST, COOL}
  - default constants `WDT_GRACE_DEF`=1024, `WDT_HOLD_DEF`=16.
- Sub-module `wdt_sync2`: 2-flop synchronizer with asynchronous active-low reset, parameter `RST_VAL`=0. Reused for any later async inputs.
- The FSM, counters and flags live in `wdt_rst_ctrl` itself.

## Test plan
- Test-only parameters: GRACE=8, HOLD=4.
- Basic escalation:
  - Stimulus: `wto_i` rises and no ack is given.
  - Required: `irq_wdt` high 8 cycles starting 2 edges after sampling; then `sys_rst_n` low 4 cycles; `rst_cause`=1; `to_count`=1; `busy` drops once `wto_i` is low.
- Acknowledge:
  - Stimulus: `irq_ack` on the 3rd IRQ cycle.
  - Required: `irq_wdt` falls next edge; `sys_rst_n` stays 1; `to_count` stays 0.
- Ack/expiry collision:
  - Stimulus: `irq_ack` in the last IRQ cycle.
  - Required: no reset; `rst_cause` stays 0.
- Level hold and retrigger:
  - Stimulus: `wto_i` held high after RST.
  - Required: FSM parks in COOL and no second IRQ occurs. Lowering then raising `wto_i` produces a second full escalation; `to_count`=2.
- Saturation and clear:
  - Stimulus: force 256 escalations with CNT_W=8.
  - Required: `to_count`=255. `cause_clr` alone gives 0 and 0. `cause_clr` coincident with an RST entry gives 1 and 1.
- Async reset:
  - Stimulus: assert `rst` mid-RST.
  - Required: `sys_rst_n`=1 immediately and all outputs at reset values. After release, a still-high `wto_i` re-triggers IRQ 2 edges later.
